// File: rtl/adc_sample_packer.sv
// adc_sample_packer: registers NCH demultiplexed ADC channels (two 8-bit
// samples per channel per clk), requantises every sample to 8/4/2/1 bits,
// packs the samples into OUT_W-bit words and buffers them in a DEPTH-word
// first-word-fall-through FIFO. The FIFO is drained with valid/ready.
// A word that finds the FIFO full is dropped. Each drop sets a sticky
// overflow flag and increments a saturating drop counter. The next stored
// word is tagged with out_sof so downstream logic can resynchronise.
module adc_sample_packer #(
    parameter int NCH   = 4,
    parameter int OUT_W = 64,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic [NCH*16-1:0]          din,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_sof,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int IN_W = NCH * 16;
    // Beats per word in the narrowest mode (1 bit per sample).
    localparam int RMAX = OUT_W / (NCH * 2);
    localparam int BC_W = $clog2(RMAX);
    localparam int AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Keep the top bits of every sample byte. This truncates and does not
    // round. Sample i = c*2+s occupies byte i of the input vector. Its field
    // lands at offset i*bps inside the beat. Unused upper beat bits stay zero.
    function automatic logic [IN_W-1:0] requant(input logic [IN_W-1:0] d,
                                                input logic [1:0]      m);
        logic [IN_W-1:0] r;
        r = '0;
        case (m)
            2'd0: for (int i = 0; i < 2*NCH; i++) r[i*8 +: 8] = d[i*8 +: 8];
            2'd1: for (int i = 0; i < 2*NCH; i++) r[i*4 +: 4] = d[i*8+4 +: 4];
            2'd2: for (int i = 0; i < 2*NCH; i++) r[i*2 +: 2] = d[i*8+6 +: 2];
            default: for (int i = 0; i < 2*NCH; i++) r[i] = d[i*8+7];
        endcase
        return r;
    endfunction

    // Index of the beat that completes a word in the given mode.
    function automatic logic [BC_W-1:0] last_beat(input logic [1:0] m);
        int mi;
        mi = int'(m);
        return BC_W'((RMAX >> (3 - mi)) - 1);
    endfunction

    // OR beat k into the word at bit k*B, where B = NCH*2*bps.
    function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] acc,
                                               input logic [IN_W-1:0]  beat,
                                               input logic [BC_W-1:0]  k,
                                               input logic [1:0]       m);
        int sh;
        sh = int'(k) * (NCH * 2 * (8 >> int'(m)));
        return acc | (OUT_W'(beat) << sh);
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    state_t               state, state_nxt;
    logic                 en_p0;
    logic [IN_W-1:0]      din_p0;
    logic [1:0]           mode_q, mode_eff;
    logic                 pack, enter, last;
    logic [BC_W-1:0]      beat_cnt;
    logic [OUT_W-1:0]     word_nxt, word_p1;
    logic                 vld_p1;

    logic [OUT_W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]     sof_mem;
    logic [AW-1:0]        wptr, rptr;
    logic                 resync;
    logic                 rd, wr_ok, drop;

    // Next state. A beat is packed on every cycle that the registered enable
    // is high, and that includes the cycle that enters RUN. On entry the live
    // mode input is used, because it is the value being latched.
    always_comb begin
        state_nxt = state;
        pack      = 1'b0;
        enter     = 1'b0;
        mode_eff  = mode_q;
        case (state)
            IDLE: begin
                if (en_p0) begin
                    state_nxt = RUN;
                    enter     = 1'b1;
                    pack      = 1'b1;
                    mode_eff  = mode;
                end
            end
            RUN: begin
                if (en_p0) pack = 1'b1;
                else       state_nxt = IDLE;
            end
        endcase
    end

    assign last     = (beat_cnt == last_beat(mode_eff));
    assign word_nxt = place((beat_cnt == '0) ? '0 : word_p1,
                            requant(din_p0, mode_eff), beat_cnt, mode_eff);

    // Control pipeline: the enable register, the FSM state, the latched mode,
    // the beat counter and the word-complete valid.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            en_p0    <= 1'b0;
            mode_q   <= 2'd0;
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state  <= state_nxt;
            en_p0  <= en;
            if (enter) mode_q <= mode;
            if (pack) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            else      beat_cnt <= '0;
            vld_p1 <= pack & last;
        end
    end

    // Data pipeline. The input sample register feeds the packing accumulator.
    // The completed word waits here for one cycle while it is written.
    always_ff @(posedge clk) begin
        din_p0 <= din;
        if (pack) word_p1 <= word_nxt;
    end

    assign out_valid = (level != '0);
    assign rd        = out_valid & out_ready;
    // A full FIFO still accepts a word if the head is read on the same edge.
    assign wr_ok     = vld_p1 & ((level < FULL) | rd);
    assign drop      = vld_p1 & ~wr_ok;

    // FIFO bookkeeping: pointers, occupancy, resync tag, overflow and the
    // drop counter. When a drop and clear occur together, the drop wins.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            resync     <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
            sof_mem    <= '0;
        end else begin
            if (wr_ok) begin
                wptr          <= wptr + 1'b1;
                sof_mem[wptr] <= resync;
            end
            if (rd) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd};

            if (enter)      resync <= 1'b1;
            else if (wr_ok) resync <= 1'b0;
            else if (drop)  resync <= 1'b1;

            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear ? CNT_W'(1) : sat_inc(drop_count);
            end else if (clear) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    // FIFO storage for word payloads.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= word_p1;
    end

    assign out_data = out_valid ? mem[rptr] : '0;
    assign out_sof  = out_valid & sof_mem[rptr];

endmodule

// File: tb/tb_adc_sample_packer.sv
// Testbench for adc_sample_packer. A behavioural model predicts which words
// are stored and how they are tagged. It pushes accepted words into a
// scoreboard queue. A monitor pops an entry whenever the DUT hands over a
// word and compares that entry with the word.
module tb_adc_sample_packer;
    localparam int NCH   = 4;
    localparam int OUT_W = 64;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int IN_W  = NCH * 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   nreset = 1'b0;
    logic                   en = 1'b0;
    logic [1:0]             mode = 2'd0;
    logic                   clear = 1'b0;
    logic [IN_W-1:0]        din = '0;
    logic [OUT_W-1:0]       out_data;
    logic                   out_sof;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_count;
    logic [$clog2(DEPTH):0] level;

    adc_sample_packer #(.NCH(NCH), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .nreset(nreset), .en(en), .mode(mode), .clear(clear), .din(din),
        .out_data(out_data), .out_sof(out_sof), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .drop_count(drop_count),
        .level(level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [OUT_W:0]    sb_q[$];        // {sof, data} of every word the FIFO should hold
    logic [IN_W-1:0]   m_beats[$];     // beats collected for the word in progress
    int                m_level, m_drops, m_mode;
    bit                m_over, m_resync, m_run, m_pend, m_en_r, m_rd, m_acc;
    logic [OUT_W-1:0]  m_pend_word;
    logic [IN_W-1:0]   m_din_r;

    function automatic int beats_per_word(input int m);
        return OUT_W / (NCH * 2 * (8 >> m));
    endfunction

    // Word from collected beats: field = top bps bits of each sample byte,
    // beat k at k*B, channel c sample s at (c*2+s)*bps within the beat.
    function automatic logic [OUT_W-1:0] build_word(input int m);
        int bps, bw;
        logic [OUT_W-1:0] w, f;
        logic [IN_W-1:0] bt;
        logic [7:0] smp;
        bps = 8 >> m;
        bw  = NCH * 2 * bps;
        w   = '0;
        for (int k = 0; k < m_beats.size(); k++) begin
            bt = m_beats[k];
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < 2; s++) begin
                    smp = bt[c*16 + s*8 +: 8];
                    f = '0;
                    f[7:0] = smp >> (8 - bps);
                    w = w | (f << (k*bw + (c*2 + s)*bps));
                end
            end
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk or negedge nreset);
        if (!nreset) begin
            m_level = 0; m_over = 0; m_drops = 0; m_resync = 1; m_run = 0;
            m_mode = 0; m_pend = 0; m_en_r = 0;
            m_beats.delete();
            sb_q.delete();
        end else begin
            m_rd  = (m_level > 0) && out_ready;
            m_acc = 0;
            if (m_pend) begin
                m_acc = (m_level < DEPTH) || m_rd;
                if (m_acc) begin
                    sb_q.push_back({m_resync, m_pend_word});
                    m_resync = 0;
                end else begin
                    m_over   = 1;
                    m_drops  = clear ? 1 : ((m_drops == MAXC) ? MAXC : m_drops + 1);
                    m_resync = 1;
                end
            end
            if (clear && !(m_pend && !m_acc)) begin
                m_over = 0;
                m_drops = 0;
            end
            m_level = m_level + int'(m_acc) - int'(m_rd);
            m_pend = 0;
            if (m_en_r) begin
                if (!m_run) begin
                    m_run = 1;
                    m_mode = int'(mode);
                    m_beats.delete();
                    m_resync = 1;
                end
                m_beats.push_back(m_din_r);
                if (m_beats.size() == beats_per_word(m_mode)) begin
                    m_pend_word = build_word(m_mode);
                    m_pend = 1;
                    m_beats.delete();
                end
            end else begin
                m_run = 0;
                m_beats.delete();
            end
            m_en_r  = en;
            m_din_r = din;
        end
    end

    // ---------------- monitor ----------------
    logic [OUT_W:0] exp_e;
    initial forever begin
        @(negedge clk);
        #2;
        if (nreset && mon_on) begin
            chk("level", OUT_W'(level), OUT_W'(m_level));
            chk("out_valid", OUT_W'(out_valid), OUT_W'(m_level > 0));
            chk("overflow", OUT_W'(overflow), OUT_W'(m_over));
            chk("drop_count", OUT_W'(drop_count), OUT_W'(m_drops));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: DUT gave 0x%0h but no word was expected", out_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    chk("data", out_data, exp_e[OUT_W-1:0]);
                    chk("sof", OUT_W'(out_sof), OUT_W'(exp_e[OUT_W]));
                end
            end
        end
    end

    task automatic wait_valid(input string nm, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!out_valid && n < limit);
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL %s: out_valid still 0 after %0d cycles, expected 1", nm, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", OUT_W'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_sof", OUT_W'(out_sof), 64'd0);
        chk("rst_overflow", OUT_W'(overflow), 64'd0);
        chk("rst_drop_count", OUT_W'(drop_count), 64'd0);
        chk("rst_level", OUT_W'(level), 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        mon_on = 1'b1;

        // Mode 0 streaming: latency 2 after registration, and sof on the first word only.
        @(negedge clk);
        mode = 2'd0; out_ready = 1'b1; din = 64'h0123456789ABCDEF; en = 1'b1;
        @(negedge clk); #2; chk("t1_lat_e0", OUT_W'(out_valid), 64'd0);
        @(negedge clk); #2; chk("t1_lat_e1", OUT_W'(out_valid), 64'd0);
        @(negedge clk); #2;
        chk("t1_first_valid", OUT_W'(out_valid), 64'd1);
        chk("t1_first_data", out_data, 64'h0123456789ABCDEF);
        chk("t1_first_sof", OUT_W'(out_sof), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            chk("t1_level_le1", OUT_W'(level <= 1), 64'd1);
            chk("t1_sof_low", OUT_W'(out_sof), 64'd0);
            chk("t1_data", out_data, 64'h0123456789ABCDEF);
        end
        @(negedge clk); en = 1'b0;
        repeat (6) @(negedge clk);

        // Mode 1: beat A5 then beat 3C form one word; two more beats form the next word.
        out_ready = 1'b0; mode = 2'd1; en = 1'b1; din = {8{8'hA5}};
        @(negedge clk); din = {8{8'h3C}};
        @(negedge clk); din = {$urandom, $urandom};
        @(negedge clk); din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        wait_valid("t2_wait", 8);
        chk("t2_word", out_data, 64'h33333333AAAAAAAA);
        chk("t2_sof", OUT_W'(out_sof), 64'd1);
        @(negedge clk); out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Overflow: 20 words into a 16-deep FIFO with no reads.
        out_ready = 1'b0; mode = 2'd0; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = {$urandom, $urandom};
            @(negedge clk);
        end
        en = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("t3_level", OUT_W'(level), 64'd16);
        chk("t3_overflow", OUT_W'(overflow), 64'd1);
        chk("t3_drop_count", OUT_W'(drop_count), 64'd4);
        @(negedge clk); out_ready = 1'b1;
        repeat (20) @(negedge clk);
        out_ready = 1'b0; en = 1'b1; din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        wait_valid("t3_resync_wait", 8);
        chk("t3_resync_sof", OUT_W'(out_sof), 64'd1);
        @(negedge clk); out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Partial word discarded in mode 2, then re-entry in mode 1.
        mode = 2'd2; en = 1'b1; din = {$urandom, $urandom};
        @(negedge clk); din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("t4_no_word", OUT_W'(level), 64'd0);
        @(negedge clk); out_ready = 1'b0; mode = 2'd1; en = 1'b1; din = {$urandom, $urandom};
        @(negedge clk); din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        wait_valid("t4_wait", 8);
        chk("t4_sof", OUT_W'(out_sof), 64'd1);
        @(negedge clk); out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Full FIFO: a write and a read on the same edge keep level at 16.
        out_ready = 1'b0; mode = 2'd0; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = {$urandom, $urandom};
            @(negedge clk);
        end
        en = 1'b0;
        repeat (4) @(negedge clk);
        #2; chk("t5_full", OUT_W'(level), 64'd16);
        @(negedge clk); en = 1'b1; din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        #2;
        chk("t5_rw_level", OUT_W'(level), 64'd16);
        chk("t5_rw_drops", OUT_W'(drop_count), 64'd4);
        // A drop on the same edge as clear: the drop wins.
        @(negedge clk); en = 1'b1; din = {$urandom, $urandom};
        @(negedge clk); en = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #2;
        chk("t5_clr_drop_count", OUT_W'(drop_count), 64'd1);
        chk("t5_clr_overflow", OUT_W'(overflow), 64'd1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #2;
        chk("t5_clear_count", OUT_W'(drop_count), 64'd0);
        chk("t5_clear_overflow", OUT_W'(overflow), 64'd0);
        @(negedge clk); out_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-run with 5 words buffered.
        out_ready = 1'b0; mode = 2'd0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = {$urandom, $urandom};
            @(negedge clk);
        end
        en = 1'b0;
        repeat (4) @(negedge clk);
        #2; chk("t6_level5", OUT_W'(level), 64'd5);
        @(negedge clk); #3; nreset = 1'b0;
        #1;
        chk("t6_rst_valid", OUT_W'(out_valid), 64'd0);
        chk("t6_rst_level", OUT_W'(level), 64'd0);
        @(negedge clk); nreset = 1'b1;
        @(negedge clk); mode = 2'd0; din = 64'hFEDCBA9876543210; en = 1'b1;
        @(negedge clk); en = 1'b0;
        wait_valid("t6_wait", 8);
        chk("t6_data", out_data, 64'hFEDCBA9876543210);
        chk("t6_sof", OUT_W'(out_sof), 64'd1);
        @(negedge clk); out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Randomised traffic: a mostly-ready phase, then a mostly-stalled phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                en        = ($urandom_range(0, 7) != 0);
                mode      = 2'($urandom_range(0, 3));
                din       = {$urandom, $urandom};
                out_ready = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                clear     = ($urandom_range(0, 63) == 0);
            end
        end
        @(negedge clk); en = 1'b0; clear = 1'b0; out_ready = 1'b1;
        n = 0;
        while (level != '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("end_level", OUT_W'(level), 64'd0);
        chk("end_sb_empty", OUT_W'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
